// File: rtl/rv_pipeline_pkg.sv
// Shared pipeline definitions: default reset PC / bubble word and the IF/ID
// register layout that ID-stage modules also consume.
package rv_pipeline_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [31:0] instr;
        logic        valid;
    } if_id_t;

    // Turns the current IF/ID contents into a bubble while keeping the pc fields.
    function automatic if_id_t make_bubble(input if_id_t cur, input logic [31:0] nop);
        if_id_t b;
        b       = cur;
        b.instr = nop;
        b.valid = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/fetch_stage_sat_counter.sv
// Up-counter with increment enable and synchronous reset that sticks at
// all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, instruction fetch over a ready handshake, IF/ID
// pipeline register with bubble insertion, and saturating event counters.
module fetch_stage
    import rv_pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT,
    parameter int          CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pc_write,
    input  logic             if_id_write,
    input  logic             branch_taken_id,
    input  logic [31:0]      branch_target_id,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    input  logic             imem_ready,
    output logic [31:0]      pc,
    output logic [31:0]      if_id_pc,
    output logic [31:0]      if_id_pc_plus4,
    output logic [31:0]      if_id_instr,
    output logic             if_id_valid,
    output logic             redirect_misaligned,
    output logic [CNT_W-1:0] fetch_count,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    if_id_t      if_id_q;
    if_id_t      if_id_d;
    logic        misaligned_q;
    logic        misaligned_d;
    logic        fetch_inc;
    logic        stall_inc;
    logic        flush_inc;
    logic [31:0] pc_plus4;

    assign pc_plus4 = pc_q + 32'd4;

    // A redirect outranks every hazard-unit hold; otherwise pc_write gates both PC and IF/ID.
    always_comb begin
        pc_d         = pc_q;
        if_id_d      = if_id_q;
        misaligned_d = 1'b0;
        fetch_inc    = 1'b0;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;
        if (branch_taken_id) begin
            pc_d         = {branch_target_id[31:2], 2'b00};
            if_id_d      = make_bubble(if_id_q, NOP_INSTR);
            flush_inc    = 1'b1;
            misaligned_d = |branch_target_id[1:0];
        end else if (pc_write) begin
            if (imem_ready) begin
                pc_d = pc_plus4;
                if (if_id_write) begin
                    if_id_d.pc       = pc_q;
                    if_id_d.pc_plus4 = pc_plus4;
                    if_id_d.instr    = imem_rdata;
                    if_id_d.valid    = 1'b1;
                    fetch_inc        = 1'b1;
                end
            end else if (if_id_write) begin
                if_id_d = make_bubble(if_id_q, NOP_INSTR);
            end
        end else begin
            stall_inc = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q             <= RESET_PC;
            if_id_q.pc       <= 32'h0000_0000;
            if_id_q.pc_plus4 <= 32'h0000_0004;
            if_id_q.instr    <= NOP_INSTR;
            if_id_q.valid    <= 1'b0;
            misaligned_q     <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            if_id_q      <= if_id_d;
            misaligned_q <= misaligned_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_fetch_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (fetch_inc),
        .count (fetch_count)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .count (stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_inc),
        .count (flush_count)
    );

    assign imem_req            = ~reset;
    assign imem_addr           = pc_q;
    assign pc                  = pc_q;
    assign if_id_pc            = if_id_q.pc;
    assign if_id_pc_plus4      = if_id_q.pc_plus4;
    assign if_id_instr         = if_id_q.instr;
    assign if_id_valid         = if_id_q.valid;
    assign redirect_misaligned = misaligned_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: hand-computed expectations checked with
// immediate assertions after each clock edge.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_write;
    logic        if_id_write;
    logic        branch_taken_id;
    logic [31:0] branch_target_id;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] pc;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        redirect_misaligned;
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
    logic [31:0] flush_count;

    // Narrow-counter instance held permanently in stall to exercise saturation.
    logic        s_imem_req;
    logic [31:0] s_imem_addr;
    logic [31:0] s_pc;
    logic [31:0] s_if_id_pc;
    logic [31:0] s_if_id_pc_plus4;
    logic [31:0] s_if_id_instr;
    logic        s_if_id_valid;
    logic        s_misaligned;
    logic [2:0]  s_fetch_count;
    logic [2:0]  s_stall_count;
    logic [2:0]  s_flush_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk                 (clk),
        .reset               (reset),
        .pc_write            (pc_write),
        .if_id_write         (if_id_write),
        .branch_taken_id     (branch_taken_id),
        .branch_target_id    (branch_target_id),
        .imem_req            (imem_req),
        .imem_addr           (imem_addr),
        .imem_rdata          (imem_rdata),
        .imem_ready          (imem_ready),
        .pc                  (pc),
        .if_id_pc            (if_id_pc),
        .if_id_pc_plus4      (if_id_pc_plus4),
        .if_id_instr         (if_id_instr),
        .if_id_valid         (if_id_valid),
        .redirect_misaligned (redirect_misaligned),
        .fetch_count         (fetch_count),
        .stall_count         (stall_count),
        .flush_count         (flush_count)
    );

    fetch_stage #(.RESET_PC(32'h0000_0200), .CNT_W(3)) dut_sat (
        .clk                 (clk),
        .reset               (reset),
        .pc_write            (1'b0),
        .if_id_write         (1'b0),
        .branch_taken_id     (1'b0),
        .branch_target_id    (32'h0),
        .imem_req            (s_imem_req),
        .imem_addr           (s_imem_addr),
        .imem_rdata          (32'h0),
        .imem_ready          (1'b0),
        .pc                  (s_pc),
        .if_id_pc            (s_if_id_pc),
        .if_id_pc_plus4      (s_if_id_pc_plus4),
        .if_id_instr         (s_if_id_instr),
        .if_id_valid         (s_if_id_valid),
        .redirect_misaligned (s_misaligned),
        .fetch_count         (s_fetch_count),
        .stall_count         (s_stall_count),
        .flush_count         (s_flush_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] e_pc, input logic [31:0] e_ifpc,
                              input logic [31:0] e_instr, input logic e_valid);
        check({tag, ".pc"}, pc, e_pc);
        check({tag, ".if_id_pc"}, if_id_pc, e_ifpc);
        check({tag, ".if_id_pc_plus4"}, if_id_pc_plus4, e_ifpc + 32'd4);
        check({tag, ".if_id_instr"}, if_id_instr, e_instr);
        check({tag, ".if_id_valid"}, {31'b0, if_id_valid}, {31'b0, e_valid});
        $display("step %s pc=%h if_id_pc=%h instr=%h valid=%0b", tag, pc, if_id_pc, if_id_instr, if_id_valid);
    endtask

    task automatic check_cnt(input string tag, input logic [31:0] f, input logic [31:0] s, input logic [31:0] fl);
        check({tag, ".fetch_count"}, fetch_count, f);
        check({tag, ".stall_count"}, stall_count, s);
        check({tag, ".flush_count"}, flush_count, fl);
    endtask

    initial begin
        reset            = 1'b1;
        pc_write         = 1'b0;
        if_id_write      = 1'b0;
        branch_taken_id  = 1'b0;
        branch_target_id = 32'h0;
        imem_rdata       = 32'h0;
        imem_ready       = 1'b0;

        // Reset state
        step();
        check_ifid("reset", 32'h0, 32'h0, 32'h0000_0013, 1'b0);
        check_cnt("reset", 0, 0, 0);
        check("reset.imem_req", {31'b0, imem_req}, 32'h0);
        check("reset.misaligned", {31'b0, redirect_misaligned}, 32'h0);
        check("reset.sat_pc", s_pc, 32'h0000_0200);
        reset = 1'b0;
        #1;
        check("run.imem_req", {31'b0, imem_req}, 32'h1);
        check("run.imem_addr", imem_addr, 32'h0);

        // Straight-line fetch of three instructions
        pc_write = 1'b1; if_id_write = 1'b1; imem_ready = 1'b1;
        imem_rdata = 32'h0050_0093; step();
        check_ifid("fetch0", 32'h4, 32'h0, 32'h0050_0093, 1'b1);
        imem_rdata = 32'h00A0_0113; step();
        check_ifid("fetch1", 32'h8, 32'h4, 32'h00A0_0113, 1'b1);
        imem_rdata = 32'h0020_81B3; step();
        check_ifid("fetch2", 32'hC, 32'h8, 32'h0020_81B3, 1'b1);
        check_cnt("fetch2", 3, 0, 0);
        imem_rdata = 32'h0000_0033; step();
        check_ifid("fetch3", 32'h10, 32'hC, 32'h0000_0033, 1'b1);
        check("fetch3.imem_addr", imem_addr, 32'h10);

        // Load-use stall: everything holds, stall counted
        pc_write = 1'b0; if_id_write = 1'b0; imem_rdata = 32'hDEAD_BEEF; step();
        check_ifid("stall", 32'h10, 32'hC, 32'h0000_0033, 1'b1);
        check_cnt("stall", 4, 1, 0);

        pc_write = 1'b1; if_id_write = 1'b1; imem_rdata = 32'h0010_0193; step();
        check_ifid("resume", 32'h14, 32'h10, 32'h0010_0193, 1'b1);
        check_cnt("resume", 5, 1, 0);

        // Redirect wins over pc_write=0
        pc_write = 1'b0; if_id_write = 1'b0; branch_taken_id = 1'b1; branch_target_id = 32'h40; step();
        check_ifid("redir", 32'h40, 32'h10, 32'h0000_0013, 1'b0);
        check_cnt("redir", 5, 1, 1);
        check("redir.misaligned", {31'b0, redirect_misaligned}, 32'h0);

        // Memory not ready: bubbles, pc holds
        branch_taken_id = 1'b0; pc_write = 1'b1; if_id_write = 1'b1; imem_ready = 1'b0;
        imem_rdata = 32'hBAD0_BAD0; step();
        check_ifid("notready0", 32'h40, 32'h10, 32'h0000_0013, 1'b0);
        step();
        check_ifid("notready1", 32'h40, 32'h10, 32'h0000_0013, 1'b0);
        check_cnt("notready1", 5, 1, 1);
        imem_ready = 1'b1; imem_rdata = 32'h0000_0113; step();
        check_ifid("ready", 32'h44, 32'h40, 32'h0000_0113, 1'b1);
        check_cnt("ready", 6, 1, 1);

        // Misaligned redirect: one-cycle pulse, target aligned down
        branch_taken_id = 1'b1; branch_target_id = 32'h102; step();
        check_ifid("misal", 32'h100, 32'h40, 32'h0000_0013, 1'b0);
        check("misal.pulse", {31'b0, redirect_misaligned}, 32'h1);
        check("misal.flush_count", flush_count, 32'd2);
        branch_taken_id = 1'b0; imem_rdata = 32'h0000_0093; step();
        check_ifid("misal_next", 32'h104, 32'h100, 32'h0000_0093, 1'b1);
        check("misal_next.pulse", {31'b0, redirect_misaligned}, 32'h0);

        // PC wrap at top of address space
        branch_taken_id = 1'b1; branch_target_id = 32'hFFFF_FFFC; step();
        check("wrap_redir.pc", pc, 32'hFFFF_FFFC);
        check("wrap_redir.misaligned", {31'b0, redirect_misaligned}, 32'h0);
        branch_taken_id = 1'b0; imem_rdata = 32'h0000_0093; step();
        check("wrap.pc", pc, 32'h0);
        check("wrap.if_id_pc", if_id_pc, 32'hFFFF_FFFC);
        check("wrap.if_id_pc_plus4", if_id_pc_plus4, 32'h0);
        check_cnt("wrap", 8, 1, 3);

        // pc_write without if_id_write: pc advances, fetched word dropped
        if_id_write = 1'b0; imem_rdata = 32'h1234_5678; step();
        check("drop.pc", pc, 32'h4);
        check("drop.if_id_pc", if_id_pc, 32'hFFFF_FFFC);
        check("drop.if_id_instr", if_id_instr, 32'h0000_0093);
        check("drop.fetch_count", fetch_count, 32'd8);

        // Mid-stream reset clears everything
        reset = 1'b1; if_id_write = 1'b1; step();
        check_ifid("midreset", 32'h0, 32'h0, 32'h0000_0013, 1'b0);
        check_cnt("midreset", 0, 0, 0);
        check("midreset.imem_req", {31'b0, imem_req}, 32'h0);
        check("midreset.sat_stall", {29'b0, s_stall_count}, 32'h0);
        reset = 1'b0; pc_write = 1'b0; if_id_write = 1'b0;

        // Narrow stall counter: counts to 7, then sticks
        for (int i = 0; i < 5; i++) step();
        check("sat.stall5", {29'b0, s_stall_count}, 32'd5);
        check("main.stall5", stall_count, 32'd5);
        for (int i = 0; i < 2; i++) step();
        check("sat.stall7", {29'b0, s_stall_count}, 32'd7);
        for (int i = 0; i < 4; i++) step();
        check("sat.stall_hold", {29'b0, s_stall_count}, 32'd7);
        check("sat.fetch", {29'b0, s_fetch_count}, 32'd0);
        check("main.stall11", stall_count, 32'd11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
